alu_writeback_stage: RTL and testbench

//  Execute/writeback stage directly downstream of the combinational 16-bit ALU.
//  - Per accepted instruction, selects one of the parallel ALU results by opcode.
//  - Updates the Z/N/C/V status register.
//  - Queues register-file writebacks in a 2-entry buffer drained over a valid/ready handshake.

---
 rtl/alu_writeback_stage_if.sv | 44 ++++
 rtl/alu_writeback_stage.sv | 110 +++++++++++
 tb/tb_alu_writeback_stage.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_writeback_stage_if.sv
// Handshake and data bundle between the ALU/upstream issue logic, the writeback
// stage and the register file write port.
interface alu_writeback_stage_if #(
    parameter int WIDTH = 16,
    parameter int RA_W  = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_opcode;
    logic [RA_W-1:0]  in_rd;
    logic [WIDTH-1:0] in_op1;
    logic [WIDTH-1:0] in_op2;
    logic [WIDTH-1:0] in_add;
    logic [WIDTH-1:0] in_sub;
    logic [WIDTH-1:0] in_and;
    logic [WIDTH-1:0] in_or;
    logic [WIDTH-1:0] in_xor;
    logic [WIDTH-1:0] in_not;
    logic [WIDTH-1:0] in_cmp;
    logic             wb_valid;
    logic             wb_ready;
    logic [RA_W-1:0]  wb_addr;
    logic [WIDTH-1:0] wb_data;
    logic             flag_z;
    logic             flag_n;
    logic             flag_c;
    logic             flag_v;

    modport master (
        output in_valid, in_opcode, in_rd, in_op1, in_op2,
        output in_add, in_sub, in_and, in_or, in_xor, in_not, in_cmp,
        output wb_ready,
        input  in_ready, wb_valid, wb_addr, wb_data,
        input  flag_z, flag_n, flag_c, flag_v
    );

    modport slave (
        input  in_valid, in_opcode, in_rd, in_op1, in_op2,
        input  in_add, in_sub, in_and, in_or, in_xor, in_not, in_cmp,
        input  wb_ready,
        output in_ready, wb_valid, wb_addr, wb_data,
        output flag_z, flag_n, flag_c, flag_v
    );
endinterface

// File: rtl/alu_writeback_stage.sv
// Execute/writeback stage: opcode result select, Z/N/C/V flags, 2-entry writeback FIFO.
// Accept-to-wb_valid latency 1; in_ready is registered and drops while full (no bypass).
module alu_writeback_stage #(
    parameter int WIDTH = 16,
    parameter int RA_W  = 3
) (
    input logic                clk,
    input logic                rst_n,
    alu_writeback_stage_if.slave io
);
    typedef enum logic [2:0] {
        OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3,
        OP_XOR = 3'd4, OP_NOT = 3'd5, OP_CMP = 3'd6, OP_NOP = 3'd7
    } opcode_e;

    typedef struct packed {
        logic [RA_W-1:0]  addr;
        logic [WIDTH-1:0] data;
    } wb_entry_t;

    wb_entry_t r_mem [2];
    logic      r_head;
    logic [1:0] r_count;
    logic      r_in_ready;
    logic      r_flag_z, r_flag_n, r_flag_c, r_flag_v;

    opcode_e          w_op;
    logic [WIDTH-1:0] w_result;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic             w_flag_c, w_flag_v;
    logic             w_accept, w_push, w_pop, w_tail;
    logic [1:0]       w_count_next;

    assign w_op   = opcode_e'(io.in_opcode);
    assign w_sum  = {1'b0, io.in_op1} + {1'b0, io.in_op2};
    // Subtract as op1 + ~op2 + 1 so the carry-out is the "no borrow" flag.
    assign w_diff = {1'b0, io.in_op1} + {1'b0, ~io.in_op2} + (WIDTH+1)'(1);

    always_comb begin
        w_result = '0;
        w_flag_c = 1'b0;
        w_flag_v = 1'b0;
        case (w_op)
            OP_ADD: begin
                w_result = io.in_add;
                w_flag_c = w_sum[WIDTH];
                w_flag_v = (io.in_op1[WIDTH-1] == io.in_op2[WIDTH-1]) &&
                           (io.in_add[WIDTH-1] != io.in_op1[WIDTH-1]);
            end
            OP_SUB: begin
                w_result = io.in_sub;
                w_flag_c = w_diff[WIDTH];
                w_flag_v = (io.in_op1[WIDTH-1] != io.in_op2[WIDTH-1]) &&
                           (io.in_sub[WIDTH-1] != io.in_op1[WIDTH-1]);
            end
            OP_CMP: begin
                w_result = io.in_cmp;
                w_flag_c = w_diff[WIDTH];
                w_flag_v = (io.in_op1[WIDTH-1] != io.in_op2[WIDTH-1]) &&
                           (io.in_cmp[WIDTH-1] != io.in_op1[WIDTH-1]);
            end
            OP_AND:  w_result = io.in_and;
            OP_OR:   w_result = io.in_or;
            OP_XOR:  w_result = io.in_xor;
            OP_NOT:  w_result = io.in_not;
            default: w_result = '0;
        endcase
    end

    assign w_accept     = io.in_valid & r_in_ready;
    assign w_push       = w_accept & (w_op <= OP_NOT);
    assign w_pop        = (r_count != 2'd0) & io.wb_ready;
    // Tail slot sits one past the head when a single entry is already queued.
    assign w_tail       = r_head ^ r_count[0];
    assign w_count_next = r_count + 2'(w_push) - 2'(w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) r_mem[i] <= '0;
            r_head     <= 1'b0;
            r_count    <= 2'd0;
            r_in_ready <= 1'b1;
            r_flag_z   <= 1'b0;
            r_flag_n   <= 1'b0;
            r_flag_c   <= 1'b0;
            r_flag_v   <= 1'b0;
        end else begin
            if (w_push) r_mem[w_tail] <= '{addr: io.in_rd, data: w_result};
            if (w_pop)  r_head <= ~r_head;
            r_count    <= w_count_next;
            r_in_ready <= (w_count_next != 2'd2);
            if (w_accept && (w_op != OP_NOP)) begin
                r_flag_z <= (w_result == '0);
                r_flag_n <= w_result[WIDTH-1];
                r_flag_c <= w_flag_c;
                r_flag_v <= w_flag_v;
            end
        end
    end

    assign io.in_ready = r_in_ready;
    assign io.wb_valid = (r_count != 2'd0);
    assign io.wb_addr  = r_mem[r_head].addr;
    assign io.wb_data  = r_mem[r_head].data;
    assign io.flag_z   = r_flag_z;
    assign io.flag_n   = r_flag_n;
    assign io.flag_c   = r_flag_c;
    assign io.flag_v   = r_flag_v;
endmodule

// File: tb/tb_alu_writeback_stage.sv
// Bench for alu_writeback_stage: directed vector table, hand-written backpressure
// and reset sequences, then randomized traffic against a queue-based reference model.
module tb_alu_writeback_stage;
    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3,
                           XOR_ = 3'd4, NOT_ = 3'd5, CMP = 3'd6, NOP = 3'd7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    alu_writeback_stage_if #(.WIDTH(16), .RA_W(3)) bus ();
    alu_writeback_stage #(.WIDTH(16), .RA_W(3)) dut (.clk(clk), .rst_n(rst_n), .io(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  rd;
        logic [15:0] op1;
        logic [15:0] op2;
        logic        push;
        logic [15:0] data;
        logic [3:0]  flags;   // {z,n,c,v}
    } vec_t;

    typedef struct packed {
        logic [2:0]  addr;
        logic [15:0] data;
    } ent_t;

    vec_t vecs[11];
    ent_t mq[$];
    logic m_ready;
    logic [3:0] m_flags;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] dut_flags();
        return {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v};
    endfunction

    task automatic drive_op(input logic [2:0] op, input logic [2:0] rd,
                            input logic [15:0] a, input logic [15:0] b);
        bus.in_opcode = op;
        bus.in_rd     = rd;
        bus.in_op1    = a;
        bus.in_op2    = b;
        bus.in_add    = a + b;
        bus.in_sub    = a - b;
        bus.in_and    = a & b;
        bus.in_or     = a | b;
        bus.in_xor    = a ^ b;
        bus.in_not    = ~a;
        bus.in_cmp    = a - b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Architectural result and flags from integer arithmetic.
    task automatic model_exec(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                              output logic [15:0] res, output logic [3:0] fl);
        int ua, ub, sa, sb, s;
        logic c, v;
        ua = int'(a); ub = int'(b);
        sa = int'($signed(a)); sb = int'($signed(b));
        c = 1'b0; v = 1'b0; res = 16'h0;
        case (op)
            ADD: begin res = 16'(ua + ub); c = (ua + ub) > 65535; s = sa + sb; v = (s > 32767) || (s < -32768); end
            SUB, CMP: begin res = 16'(ua - ub); c = (ua >= ub); s = sa - sb; v = (s > 32767) || (s < -32768); end
            AND_: res = a & b;
            OR_:  res = a | b;
            XOR_: res = a ^ b;
            NOT_: res = ~a;
            default: res = 16'h0;
        endcase
        fl = {res == 16'h0, res[15], c, v};
    endtask

    function automatic logic [15:0] pick_val();
        logic [15:0] edges [6];
        edges = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h8001};
        if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 5)];
        return 16'($urandom);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] res;
        logic [3:0]  fl;
        logic        v_in, acc;

        vecs[0]  = '{ADD,  3'd2, 16'h7FFF, 16'h0001, 1'b1, 16'h8000, 4'b0101};
        vecs[1]  = '{CMP,  3'd5, 16'h0005, 16'h0005, 1'b0, 16'h0000, 4'b1010};
        vecs[2]  = '{ADD,  3'd7, 16'hFFFF, 16'h0001, 1'b1, 16'h0000, 4'b1010};
        vecs[3]  = '{NOP,  3'd1, 16'h1234, 16'h4321, 1'b0, 16'h0000, 4'b1010};
        vecs[4]  = '{SUB,  3'd1, 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 4'b0100};
        vecs[5]  = '{SUB,  3'd3, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 4'b0011};
        vecs[6]  = '{AND_, 3'd4, 16'hF0F0, 16'h0FF0, 1'b1, 16'h00F0, 4'b0000};
        vecs[7]  = '{OR_,  3'd6, 16'h0000, 16'h0000, 1'b1, 16'h0000, 4'b1000};
        vecs[8]  = '{XOR_, 3'd0, 16'hAAAA, 16'h5555, 1'b1, 16'hFFFF, 4'b0100};
        vecs[9]  = '{NOT_, 3'd5, 16'h00FF, 16'h1234, 1'b1, 16'hFF00, 4'b0100};
        vecs[10] = '{CMP,  3'd2, 16'h7FFF, 16'hFFFF, 1'b0, 16'h0000, 4'b0101};

        bus.in_valid = 1'b0;
        bus.wb_ready = 1'b0;
        drive_op(NOP, 3'd0, 16'h0, 16'h0);

        #12;
        check("rst_wb_valid", bus.wb_valid, 1'b0);
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_wb_addr",  bus.wb_addr, 3'd0);
        check("rst_wb_data",  bus.wb_data, 16'h0);
        check("rst_flags",    dut_flags(), 4'b0000);
        rst_n = 1'b1;
        tick();

        // Directed table: one instruction at a time into an empty buffer.
        bus.wb_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            check("vec_in_ready", bus.in_ready, 1'b1);
            drive_op(vecs[i].op, vecs[i].rd, vecs[i].op1, vecs[i].op2);
            bus.in_valid = 1'b1;
            tick();
            bus.in_valid = 1'b0;
            check($sformatf("vec%0d_wb_valid", i), bus.wb_valid, vecs[i].push);
            if (vecs[i].push) begin
                check($sformatf("vec%0d_wb_addr", i), bus.wb_addr, vecs[i].rd);
                check($sformatf("vec%0d_wb_data", i), bus.wb_data, vecs[i].data);
            end
            check($sformatf("vec%0d_flags", i), dut_flags(), vecs[i].flags);
            tick();
            check($sformatf("vec%0d_drained", i), bus.wb_valid, 1'b0);
        end

        // Backpressure: fill, hold a third, then drain in order.
        bus.wb_ready = 1'b0;
        drive_op(ADD, 3'd1, 16'h1111, 16'h2222);
        bus.in_valid = 1'b1;
        tick();
        check("bp1_in_ready", bus.in_ready, 1'b1);
        check("bp1_wb_data", bus.wb_data, 16'h3333);
        drive_op(SUB, 3'd2, 16'h5000, 16'h1000);
        tick();
        check("bp2_in_ready", bus.in_ready, 1'b0);
        check("bp2_wb_addr", bus.wb_addr, 3'd1);
        drive_op(XOR_, 3'd3, 16'h00FF, 16'h0F0F);
        tick();
        check("bp3_in_ready", bus.in_ready, 1'b0);
        check("bp3_stable_addr", bus.wb_addr, 3'd1);
        check("bp3_stable_data", bus.wb_data, 16'h3333);
        check("bp3_flags_sub", dut_flags(), 4'b0010);
        bus.wb_ready = 1'b1;
        tick();
        check("bp4_in_ready", bus.in_ready, 1'b1);
        check("bp4_wb_addr", bus.wb_addr, 3'd2);
        check("bp4_wb_data", bus.wb_data, 16'h4000);
        tick();
        bus.in_valid = 1'b0;
        check("bp5_wb_valid", bus.wb_valid, 1'b1);
        check("bp5_wb_addr", bus.wb_addr, 3'd3);
        check("bp5_wb_data", bus.wb_data, 16'h0FF0);
        check("bp5_flags", dut_flags(), 4'b0000);
        tick();
        check("bp6_wb_valid", bus.wb_valid, 1'b0);

        // Reset with two entries queued.
        bus.wb_ready = 1'b0;
        drive_op(ADD, 3'd4, 16'hFFFF, 16'hFFFF);
        bus.in_valid = 1'b1;
        tick();
        drive_op(SUB, 3'd5, 16'h8000, 16'h0001);
        tick();
        bus.in_valid = 1'b0;
        check("prerst_in_ready", bus.in_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mrst_wb_valid", bus.wb_valid, 1'b0);
        check("mrst_in_ready", bus.in_ready, 1'b1);
        check("mrst_flags", dut_flags(), 4'b0000);
        check("mrst_wb_data", bus.wb_data, 16'h0);
        #1;
        rst_n = 1'b1;
        tick();
        check("postrst_wb_valid", bus.wb_valid, 1'b0);

        // Random traffic against the reference model.
        mq.delete();
        m_ready = 1'b1;
        m_flags = 4'b0000;
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic [2:0]  op;
            logic [2:0]  rd;
            logic [15:0] a, b;
            op = 3'($urandom_range(0, 7));
            rd = 3'($urandom_range(0, 7));
            a = pick_val();
            b = pick_val();
            v_in = ($urandom_range(0, 9) < 7);
            drive_op(op, rd, a, b);
            bus.in_valid = v_in;
            bus.wb_ready = ($urandom_range(0, 9) < 5);

            model_exec(op, a, b, res, fl);
            acc = v_in && m_ready;
            if (mq.size() > 0 && bus.wb_ready) void'(mq.pop_front());
            if (acc && op <= NOT_) mq.push_back('{addr: rd, data: res});
            if (acc && op != NOP) m_flags = fl;
            m_ready = (mq.size() != 2);

            tick();
            check("rnd_in_ready", bus.in_ready, m_ready);
            check("rnd_wb_valid", bus.wb_valid, mq.size() != 0);
            if (mq.size() != 0) begin
                check("rnd_wb_addr", bus.wb_addr, mq[0].addr);
                check("rnd_wb_data", bus.wb_data, mq[0].data);
            end
            check("rnd_flags", dut_flags(), m_flags);
        end
        bus.in_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
